// File: rtl/sector_prot_pkg.sv
// Shared encodings and helpers for the sector-protection controller.
package sector_prot_pkg;

    localparam logic [2:0] OP_PROT       = 3'd0;
    localparam logic [2:0] OP_UNPROT     = 3'd1;
    localparam logic [2:0] OP_PROT_ALL   = 3'd2;
    localparam logic [2:0] OP_UNPROT_ALL = 3'd3;
    localparam logic [2:0] OP_LOCK       = 3'd4;
    localparam logic [2:0] OP_FREEZE     = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Sector-field width; a single-sector design still needs one index bit.
    function automatic int sec_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic sec_in_range(input int unsigned idx, input int unsigned n);
        return (idx < n);
    endfunction

endpackage

// File: rtl/sector_protection_ctrl_if.sv
// Command handshake bundle between a requester and the protection controller.
interface sector_protection_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr,
        input  cmd_ready, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr,
        output cmd_ready, busy, done, err
    );
endinterface

// File: rtl/sector_prot_lookup.sv
// Combinational sector decode and fail-safe protection lookup.
module sector_prot_lookup
    import sector_prot_pkg::*;
#(
    parameter int NUM_SECTORS = 16,
    parameter int ADDR_W      = 32,
    parameter int SEC_LSB     = 18,
    parameter int SEC_W       = 4
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic [NUM_SECTORS-1:0] prot_map,
    input  logic [NUM_SECTORS-1:0] lock_map,
    output logic [SEC_W-1:0]       idx,
    output logic                   in_range,
    output logic                   protect,
    output logic [7:0]             prot_data,
    output logic                   lock
);

    // Out-of-range sectors read as protected and locked so nothing can slip through.
    always_comb begin
        idx      = SEC_W'(addr >> SEC_LSB);
        in_range = sec_in_range(32'(idx), NUM_SECTORS);
        if (in_range) begin
            protect = prot_map[idx];
            lock    = lock_map[idx];
        end else begin
            protect = 1'b1;
            lock    = 1'b1;
        end
        prot_data = protect ? 8'hFF : 8'h00;
    end

endmodule

// File: rtl/sector_protection_ctrl.sv
// Per-sector protect/lockdown register file with a delayed-commit command FSM.
module sector_protection_ctrl
    import sector_prot_pkg::*;
#(
    parameter int NUM_SECTORS = 16,
    parameter int ADDR_W      = 32,
    parameter int SEC_LSB     = 18,
    parameter int PROG_CYCLES = 8,
    parameter int RESET_PROT  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sector_protection_ctrl_if.slave bus,
    input  logic [ADDR_W-1:0]      chk_addr,
    output logic                   protect_signal,
    output logic [7:0]             prot_data_out,
    output logic                   lock_status,
    output logic                   frozen,
    output logic [NUM_SECTORS-1:0] prot_map
);

    localparam int SEC_W = sec_w(NUM_SECTORS);
    localparam int CNT_W = $clog2(PROG_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PROG_CYCLES - 1);
    localparam logic [NUM_SECTORS-1:0] PROT_INIT =
        (RESET_PROT != 0) ? {NUM_SECTORS{1'b1}} : {NUM_SECTORS{1'b0}};

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [2:0]             op_r;
    logic [SEC_W-1:0]       sec_r;
    logic [NUM_SECTORS-1:0] prot_r;
    logic [NUM_SECTORS-1:0] lock_r;
    logic                   frozen_r;
    logic                   ready_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   err_r;

    logic [SEC_W-1:0]       cmd_sec_s;
    logic                   cmd_in_range_s;
    logic                   reject_s;
    logic [NUM_SECTORS-1:0] prot_nxt_s;
    logic [NUM_SECTORS-1:0] lock_nxt_s;
    logic                   frozen_nxt_s;
    logic [SEC_W-1:0]       chk_idx_s;
    logic                   chk_in_range_s;

    sector_prot_lookup #(
        .NUM_SECTORS (NUM_SECTORS),
        .ADDR_W      (ADDR_W),
        .SEC_LSB     (SEC_LSB),
        .SEC_W       (SEC_W)
    ) u_lookup (
        .addr      (chk_addr),
        .prot_map  (prot_r),
        .lock_map  (lock_r),
        .idx       (chk_idx_s),
        .in_range  (chk_in_range_s),
        .protect   (protect_signal),
        .prot_data (prot_data_out),
        .lock      (lock_status)
    );

    // Accept-time legality check; ordering guards the lock lookup against bad indices.
    always_comb begin
        cmd_sec_s      = SEC_W'(bus.cmd_addr >> SEC_LSB);
        cmd_in_range_s = sec_in_range(32'(cmd_sec_s), NUM_SECTORS);
        reject_s       = 1'b0;
        if (bus.cmd_op > OP_FREEZE) begin
            reject_s = 1'b1;
        end else if (frozen_r) begin
            reject_s = 1'b1;
        end else if (((bus.cmd_op == OP_PROT) || (bus.cmd_op == OP_UNPROT) ||
                      (bus.cmd_op == OP_LOCK)) && !cmd_in_range_s) begin
            reject_s = 1'b1;
        end else if ((bus.cmd_op == OP_UNPROT) && lock_r[cmd_sec_s]) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
    end

    // Register image after the latched command commits; locked sectors never lose protection.
    always_comb begin
        prot_nxt_s   = prot_r;
        lock_nxt_s   = lock_r;
        frozen_nxt_s = frozen_r;
        case (op_r)
            OP_PROT:       prot_nxt_s[sec_r] = 1'b1;
            OP_UNPROT:     prot_nxt_s[sec_r] = lock_r[sec_r];
            OP_PROT_ALL:   prot_nxt_s = {NUM_SECTORS{1'b1}};
            OP_UNPROT_ALL: prot_nxt_s = prot_r & lock_r;
            OP_LOCK: begin
                prot_nxt_s[sec_r] = 1'b1;
                lock_nxt_s[sec_r] = 1'b1;
            end
            OP_FREEZE:     frozen_nxt_s = 1'b1;
            default: begin
                prot_nxt_s   = prot_r;
                lock_nxt_s   = lock_r;
                frozen_nxt_s = frozen_r;
            end
        endcase
    end

    // Command FSM: registers only change on the final BUSY cycle, so reset mid-flight aborts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= 3'd0;
            sec_r    <= {SEC_W{1'b0}};
            prot_r   <= PROT_INIT;
            lock_r   <= {NUM_SECTORS{1'b0}};
            frozen_r <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    if (bus.cmd_valid) begin
                        op_r    <= bus.cmd_op;
                        sec_r   <= cmd_sec_s;
                        ready_r <= 1'b0;
                        if (reject_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                        end else begin
                            state_r <= ST_BUSY;
                            busy_r  <= 1'b1;
                            cnt_r   <= CNT_LOAD;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        prot_r   <= prot_nxt_s;
                        lock_r   <= lock_nxt_s;
                        frozen_r <= frozen_nxt_s;
                        state_r  <= ST_DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        err_r    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready = ready_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign frozen        = frozen_r;
    assign prot_map      = prot_r;

endmodule

// File: doc/sector_protection_ctrl.md
Name: sector_protection_ctrl

Overview:
Parametrised, clocked sector-protection controller for the flash model.
- Holds one protect bit and one lockdown bit per sector, plus a global freeze bit.
- Accepts protect, unprotect, global and lockdown commands through a valid/ready handshake, applies a programmable commit delay, and reports completion and errors.
- Provides a combinational protection lookup for the array read/program/erase path.

Parameters:
NUM_SECTORS, 16, number of sectors (2..256, need not be a power of two)
ADDR_W, 32, width of the byte addresses on cmd_addr and chk_addr
SEC_LSB, 18, lowest address bit of the sector field; sector index = addr[SEC_LSB +: SEC_W], with SEC_W = clog2(NUM_SECTORS)
PROG_CYCLES, 8, commit delay in clk cycles for register writes (>=1)
RESET_PROT, 1, reset value of every protect bit

Ports:
clk  in  1  block clock; all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready
cmd_op  in  3  0=PROT, 1=UNPROT, 2=PROT_ALL, 3=UNPROT_ALL, 4=LOCK, 5=FREEZE, 6/7 illegal
cmd_addr  in  ADDR_W  byte address selecting the target sector
busy  out  1  high in BUSY
done  out  1  one-cycle completion pulse
err  out  1  valid only with done; 1 = command rejected and no state changed
chk_addr  in  ADDR_W  lookup address
protect_signal  out  1  protect bit of the sector at chk_addr
prot_data_out  out  8  8'hFF if protect_signal is 1, else 8'h00
lock_status  out  1  lockdown bit of the sector at chk_addr
frozen  out  1  global freeze bit
prot_map  out  NUM_SECTORS  all protect bits (bit i = sector i)

Behaviour:
- Reset (async, rst_n=0):
  - prot bits = RESET_PROT; lock bits = 0; frozen = 0.
  - State = IDLE; cmd_ready = 1; busy = done = err = 0; counter = 0.
- States: IDLE, BUSY, DONE.
- Accept (IDLE, cmd_valid=1): latch op and sector index. Reject with err=1 if any of these holds:
  - op is 6 or 7;
  - frozen = 1;
  - op is PROT, UNPROT or LOCK and the sector index >= NUM_SECTORS;
  - op is UNPROT and the sector is locked.
- Rejected command: IDLE -> DONE next cycle; done=1, err=1; no state change.
- Legal command: IDLE -> BUSY, counter loaded with PROG_CYCLES-1.
  - BUSY decrements the counter each cycle.
  - On the cycle the counter is 0, the update is written and the state moves to DONE.
  - DONE lasts one cycle (done=1, err=0), then returns to IDLE.
  - Accept-to-done latency = PROG_CYCLES+1 cycles.
  - The new state is visible on the lookup outputs in the DONE cycle.
- Command effects:
  - PROT: set prot[s].
  - UNPROT: clear prot[s].
  - PROT_ALL: set all prot bits.
  - UNPROT_ALL: clear prot bits of unlocked sectors only; not an error.
  - LOCK: set lock[s] and prot[s].
  - FREEZE: set frozen; every later command is rejected until reset.
- Locked sectors stay protected until reset. Re-LOCK or PROT of a locked sector is legal and leaves it unchanged.
- cmd_valid is ignored outside IDLE. cmd_addr and cmd_op are sampled only at accept.
- Lookup is combinational on chk_addr. An index >= NUM_SECTORS reads protect_signal=1, prot_data_out=8'hFF, lock_status=1 (fail-safe).
- Reset asserted mid-BUSY aborts the command: no partial write, no done pulse.
- Counter width = clog2(PROG_CYCLES+1). With PROG_CYCLES=1, BUSY lasts one cycle.

Decomposition:
- Package sector_prot_pkg: cmd_op encodings (localparams), state enum typedef, and a clog2-based SEC_W helper.
- One natural sub-module, sector_prot_lookup: the combinational index decode, range check and output mux. It is instantiated once for chk_addr; its range check is reused for cmd_addr.

Test Plan:
- Reset with RESET_PROT=1 -> prot_map=16'hFFFF, lock_status=0, frozen=0, cmd_ready=1, done=0.
- UNPROT at addr 0x0008_0000 (sector 2), PROG_CYCLES=8 -> busy for 8 cycles, done 9 cycles after accept with err=0; chk_addr=0x0008_0000 gives protect_signal=0, prot_data_out=8'h00; prot_map=16'hFFFB.
- LOCK sector 5, then UNPROT sector 5 -> second command done with err=1 after 1 cycle; UNPROT_ALL -> prot_map=16'h0020.
- FREEZE, then PROT_ALL -> err=1 and prot_map unchanged; PROT any sector -> err=1; after reset, PROT_ALL succeeds.
- NUM_SECTORS=12: PROT at sector index 13 -> err=1; chk_addr in sector 14 -> protect_signal=1, prot_data_out=8'hFF, lock_status=1; cmd_op=7 -> err=1.
- Assert rst_n=0 on the 4th BUSY cycle of UNPROT sector 3 -> no done pulse; prot_map=all ones after release.
